// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one busy bit per architectural register, set on
// accepted issue, cleared on writeback, gating issue on RAW/WAW hazards.
module reg_scoreboard #(
  parameter  int NREG = 32,
  parameter  int CNTW = 16,
  localparam int IW   = $clog2(NREG),
  localparam int PW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [NREG-1:0] issue_dst_oh,
  input  logic [IW-1:0]   src_a,
  input  logic [IW-1:0]   src_b,
  input  logic            src_a_used,
  input  logic            src_b_used,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [NREG-1:0] wb_dst_oh,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic [PW-1:0]   pending,
  output logic [CNTW-1:0] stall_cnt,
  output logic            onehot_err
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            err_q, err_d;

  logic [NREG-1:0] wb_mask, set_mask, eff;
  logic            hazard, issue_acc, multi_issue, multi_wb;

  always_comb begin
    wb_mask    = wb_valid ? wb_dst_oh : '0;
    wb_mask[0] = 1'b0;
    // A same-cycle writeback retires the hazard, so it is removed before lookup.
    eff        = busy_q & ~wb_mask;
    hazard     = (src_a_used & eff[src_a]) | (src_b_used & eff[src_b]) |
                 (|(issue_dst_oh & eff));
    issue_ready = !hazard && !flush;
    issue_acc   = issue_valid && issue_ready;

    set_mask    = issue_acc ? issue_dst_oh : '0;
    set_mask[0] = 1'b0;
    // OR-ing the set after the clear lets a new write win over a retiring one.
    busy_d      = flush ? '0 : (eff | set_mask);

    pending_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pending_d = pending_d + PW'(busy_d[i]);
    end

    stall_d = stall_q;
    if (issue_valid && !issue_ready && !flush && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end

    // x & (x-1) is nonzero exactly when two or more bits are set.
    multi_issue = (issue_dst_oh & (issue_dst_oh - 1'b1)) != '0;
    multi_wb    = (wb_dst_oh & (wb_dst_oh - 1'b1)) != '0;
    err_d       = err_q | (issue_valid & multi_issue) | (wb_valid & multi_wb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      pending_q <= '0;
      stall_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end

  assign busy       = busy_q;
  assign pending    = pending_q;
  assign stall_cnt  = stall_q;
  assign onehot_err = err_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard for the 32-bit RISC pipeline. Sits directly downstream of the 5-to-32 destination decoder: it takes the decoder's one-hot destination vector at issue and a one-hot writeback vector at completion, and keeps one busy bit per architectural register. It gates instruction issue with `issue_ready` whenever a source or destination register has a write still in flight, and it counts stall cycles for performance monitoring.

## Interface
- `NREG`, 32, number of architectural registers; one-hot vector width.
- `CNTW`, 16, stall-counter width.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: decode stage presents an instruction.
- `issue_dst_oh` in NREG: one-hot destination from the 5-to-32 decoder; all-zero means no register write.
- `src_a`, `src_b` in 5: source register indices.
- `src_a_used`, `src_b_used` in 1: the corresponding source is read.
- `issue_ready` out 1: combinational; the instruction is accepted on a cycle where `issue_valid && issue_ready`.
- `wb_valid` in 1: writeback completes this cycle.
- `wb_dst_oh` in NREG: one-hot register being written back.
- `flush` in 1: pipeline flush; abandon all pending writes.
- `busy` out NREG: registered pending-write bits.
- `pending` out 6: registered popcount of `busy`, range 0..31.
- `stall_cnt` out CNTW: saturating count of stalled cycles.
- `onehot_err` out 1: sticky; set when any one-hot input has more than one bit set.

## Operation
- Bit 0 (R0) is hardwired zero and is never busy. Bit 0 is masked on both set and clear.
- Effective busy: `eff = busy & ~(wb_valid ? wb_dst_oh : 0)`. A same-cycle writeback counts as complete, so it bypasses the hazard.
- A hazard exists when any of these holds:
  - `src_a_used` and `eff[src_a]`
  - `src_b_used` and `eff[src_b]`
  - `(issue_dst_oh & eff) != 0` (WAW)
- `issue_ready = !hazard && !flush`.
- Next-state busy, applied in this priority order:
  - `flush`: busy becomes 0. Issue and writeback in the same cycle are ignored.
  - Otherwise, clear the `wb_dst_oh` bits when `wb_valid`, then set the `issue_dst_oh` bits when an issue is accepted.
  - Set wins over clear on the same bit in the same cycle. Busy stays 1 because a new write is pending.
- A writeback to a non-busy register is harmless: no change and no error.
- `pending` is the popcount of next-state busy, registered alongside `busy`.
- `stall_cnt` increments when `issue_valid && !issue_ready && !flush`. It saturates at 2^CNTW−1 and is not cleared by flush.
- `onehot_err` sets when `issue_valid` is high and `issue_dst_oh` has two or more bits set, or when `wb_valid` is high and `wb_dst_oh` has two or more bits set.
  - The offending vector is still applied bitwise.
  - `onehot_err` clears only on reset.

## Timing
- Reset values: `busy`=0, `pending`=0, `stall_cnt`=0, `onehot_err`=0. With no inputs active, `issue_ready`=1.
- Reset assertion takes effect immediately, mid-operation included; all pending state is discarded.
- `issue_ready` has zero latency: it is a pure function of registered `busy` and the current-cycle inputs.
- `busy`, `pending`, `stall_cnt`, `onehot_err` have one-cycle latency and are visible the cycle after the causing edge.
- RAW on a back-to-back dependent pair:
  - Cycle N: issue writes R5, accepted.
  - Cycle N+1: dependent reading R5 stalls.
  - First cycle with `wb_valid`/R5: dependent is ready in that same cycle.
- No combinational path from `issue_valid` to `issue_ready`.

## Test plan
- Reset, then issue R3 (`issue_dst_oh`=0x8) -> `busy`=0x00000008 and `pending`=1 next cycle; `issue_ready` stays 1 during the issue cycle.
- With R3 busy, issue `src_a`=3 (`src_a_used`=1) for 4 cycles -> `issue_ready`=0 for all 4 and `stall_cnt`=4. Assert `wb_valid` with `wb_dst_oh`=0x8 -> `issue_ready`=1 that same cycle, `busy`=0 after.
- Same cycle: `wb_dst_oh`=0x20 and accepted issue with `issue_dst_oh`=0x20, R5 previously busy -> issue accepted and `busy[5]`=1 afterwards.
- Issue with `issue_dst_oh`=0x1 (R0) and a source of R0 -> never stalls; `busy`=0; `pending`=0.
- Fill R1..R31 busy, then assert `flush` with a concurrent issue of R7 -> `issue_ready`=0 in the flush cycle, then `busy`=0 and `pending`=0; `stall_cnt` unchanged.
- Apply `wb_dst_oh`=0x6 with `wb_valid` -> `onehot_err`=1 and stays 1 until `rst_n` goes low. Preload `stall_cnt` near max with CNTW=4 and stall 20 cycles -> holds at 15.
